// File: rtl/xunit_msched.sv
// xunit_msched: SHA-256 message schedule, W[0..63] one word per clock.
// Optional K[t] output and ROM enabled by define XUNIT_MSCHED_KOUT_EN.
module xunit_msched #(
  parameter int DELAY_W = 8,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic               valid,
  output logic               done,
  input  logic [DELAY_W-1:0] delay0
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACTIVE
  } state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [6:0]         t_q, t_d;
  logic [DATA_W-1:0]  w_q [16];
  logic [DATA_W-1:0]  w_d [16];
  logic [DATA_W-1:0]  out0_q, out0_d;
  logic               valid_q, valid_d;
  logic               step;
  logic [DATA_W-1:0]  w_new;

  function automatic logic [DATA_W-1:0] sig0(
    input logic [DATA_W-1:0] x
  );
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(
    input logic [DATA_W-1:0] x
  );
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ (x >> 10);
  endfunction

`ifdef XUNIT_MSCHED_KOUT_EN
  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [DATA_W-1:0] k_q, k_d;
  assign out1 = k_q;
`else
  assign out1 = '0;
`endif

  // A step fires on the last delay cycle too, so delay0=0 samples M[0]
  // on the edge right after run.
  assign step = ((state_q == DELAY) && (cnt_q == '0))
             || ((state_q == ACTIVE) && (t_q < 7'd64));

  // Next word: direct input for t<16, otherwise the schedule recurrence.
  always_comb begin
    if (t_q < 7'd16) begin
      w_new = in0;
    end else begin
      w_new = sig1(w_q[14]) + w_q[9]
            + sig0(w_q[1]) + w_q[0];
    end
  end

  // Next-state: sequencing, window shift, restart has priority.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    w_d     = w_q;
    out0_d  = out0_q;
    valid_d = valid_q;
`ifdef XUNIT_MSCHED_KOUT_EN
    k_d     = k_q;
`endif
    unique case (state_q)
      DELAY: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      end
      ACTIVE: begin
        if (t_q == 7'd64) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (step) begin
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = w_new;
      out0_d  = w_new;
      valid_d = 1'b1;
      t_d     = t_q + 7'd1;
      state_d = ACTIVE;
`ifdef XUNIT_MSCHED_KOUT_EN
      k_d     = K_ROM[t_q[5:0]];
`endif
    end
    if (run) begin
      state_d = DELAY;
      cnt_d   = delay0;
      t_d     = '0;
      valid_d = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      t_q     <= '0;
      w_q     <= '{default: '0};
      out0_q  <= '0;
      valid_q <= 1'b0;
`ifdef XUNIT_MSCHED_KOUT_EN
      k_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      w_q     <= w_d;
      out0_q  <= out0_d;
      valid_q <= valid_d;
`ifdef XUNIT_MSCHED_KOUT_EN
      k_q     <= k_d;
`endif
    end
  end

  assign out0  = out0_q;
  assign valid = valid_q;
  assign done  = (state_q == IDLE);

endmodule

// File: tb/tb_xunit_msched.sv
// tb_xunit_msched: directed vectors for the SHA-256 message schedule.
// Uses the "abc" block; checks latency, restart and reset corners.
module tb_xunit_msched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [31:0] in0 = '0;
  logic [7:0]  delay0 = '0;
  logic [31:0] out0, out1;
  logic        valid, done;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] in0;
    logic [31:0] exp_w;
    logic [31:0] exp_k;
    bit          chk_k;
  } vec_t;

  vec_t vec [64];

  xunit_msched #(.DELAY_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .in0(in0),
    .out0(out0), .out1(out1), .valid(valid),
    .done(done), .delay0(delay0)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(
    input logic [31:0] x, input int n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_vec();
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i == 0) w[i] = 32'h61626380;
      else if (i == 15) w[i] = 32'h00000018;
      else if (i < 16) w[i] = 32'h0;
      else w[i] = s1(w[i-2]) + w[i-7]
                + s0(w[i-15]) + w[i-16];
      vec[i].in0   = (i < 16) ? w[i] : 32'h0;
      vec[i].exp_w = w[i];
`ifdef XUNIT_MSCHED_KOUT_EN
      vec[i].chk_k = (i == 0) || (i == 63);
      vec[i].exp_k = (i == 0) ? 32'h428A2F98
                              : 32'hC67178F2;
`else
      vec[i].chk_k = 1'b1;
      vec[i].exp_k = 32'h0;
`endif
    end
  endtask

  // kind: 0 none, 1 restart by run at step abort_at, 2 reset there
  task automatic stream(input int dly, input int abort_at,
                        input int kind, input bit skip_run);
    int s;
    logic ev;
    delay0 = dly[7:0];
    if (!skip_run) begin
      run = 1'b1;
      tick();
      run = 1'b0;
      chk("done_fall", done, 1'b0);
      chk("valid_pre", valid, 1'b0);
    end
    for (int e = 1; e <= dly + 65; e++) begin
      s = e - 1 - dly;
      in0 = (s >= 0 && s < 16) ? vec[s].in0 : $urandom();
      if (kind == 2 && s == abort_at) begin
        rst = 1'b0;
        #1;
        chk("rst_out0", out0, 32'h0);
        chk("rst_out1", out1, 32'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_done", done, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk("rst_idle_valid", valid, 1'b0);
        chk("rst_idle_out0", out0, 32'h0);
        return;
      end
      if (kind == 1 && s == abort_at) run = 1'b1;
      tick();
      run = 1'b0;
      if (kind == 1 && s == abort_at) begin
        chk("restart_valid", valid, 1'b0);
        chk("restart_done", done, 1'b0);
        if (s == 63) chk("restart_w63", out0, vec[63].exp_w);
        return;
      end
      ev = (s >= 0) && (s < 64);
      chk("valid", valid, ev);
      chk("done", done, (e == dly + 65));
      if (ev) begin
        chk($sformatf("w%0d", s), out0, vec[s].exp_w);
        if (vec[s].chk_k)
          chk($sformatf("k%0d", s), out1, vec[s].exp_k);
        if (s == 16) chk("w16_ref", out0, 32'h61626380);
        if (s == 17) chk("w17_ref", out0, 32'h000F0000);
        if (s == 63) chk("w63_ref", out0, 32'h12B1EDEB);
      end
    end
  endtask

  initial begin
    build_vec();

    // reset with run held high
    rst = 1'b0;
    run = 1'b1;
    tick();
    tick();
    chk("reset_out0", out0, 32'h0);
    chk("reset_out1", out1, 32'h0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_done", done, 1'b1);
    run = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in0 = $urandom();
      tick();
      chk("idle_valid", valid, 1'b0);
      chk("idle_done", done, 1'b1);
      chk("idle_out0", out0, 32'h0);
    end

    // abc block, no delay; out0 holds W[63] afterwards
    stream(0, -1, 0, 1'b0);
    tick();
    chk("hold_w63", out0, 32'h12B1EDEB);
    chk("hold_done", done, 1'b1);

    // delayed starts
    stream(5, -1, 0, 1'b0);
    stream(255, -1, 0, 1'b0);

    // restart mid-stream and on the final step
    stream(0, 30, 1, 1'b0);
    stream(0, -1, 0, 1'b1);
    stream(3, 63, 1, 1'b0);
    stream(3, -1, 0, 1'b1);

    // reset mid-stream, then a clean run
    stream(0, 40, 2, 1'b0);
    stream(0, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
